// File: rtl/ddr_avl_arbiter.sv
// ddr_avl_arbiter
//   Shares one DDR3 Avalon-MM user port between a burst-2 writer (sample
//   recorder) and a burst-2 reader (alarm playback). Owns command sequencing,
//   write/read arbitration with read-starvation protection, the outstanding
//   read limit and the read return path.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   init_done_i           calibration complete; gates command issue
//   wr_req_i/addr/data    write request (level), beat0 in upper half
//   wr_ack_o, wr_done_o   request captured / both beats accepted (pulses)
//   rd_req_i/addr         read request (level)
//   rd_ack_o              read command accepted (pulse)
//   rd_data_o/valid/last  returned beats, last marks second beat
//   rd_outstanding_o      read bursts in flight
//   err_unexp_rd_o        sticky: stray readdatavalid
//   avl_*                 Avalon-MM master side
module ddr_avl_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int DATA_W        = 64,
  parameter int RD_STARVE_MAX = 8,
  parameter int MAX_RD_OUT    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                init_done_i,
  input  logic                wr_req_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  output logic                wr_ack_o,
  output logic                wr_done_o,
  input  logic                rd_req_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic                rd_ack_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_data_valid_o,
  output logic                rd_beat_last_o,
  output logic [2:0]          rd_outstanding_o,
  output logic                err_unexp_rd_o,
  output logic [ADDR_W-1:0]   avl_address_o,
  output logic                avl_write_o,
  output logic                avl_read_o,
  output logic [DATA_W-1:0]   avl_writedata_o,
  output logic                avl_beginbursttransfer_o,
  output logic [3:0]          avl_burstcount_o,
  output logic [7:0]          avl_byteenable_o,
  input  logic [DATA_W-1:0]   avl_readdata_i,
  input  logic                avl_readdatavalid_i,
  input  logic                avl_ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR0  = 2'd1;
  localparam logic [1:0] S_WR1  = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;

  localparam int          SW         = $clog2(RD_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(RD_STARVE_MAX);
  localparam logic [2:0]  MAX_OUT    = 3'(MAX_RD_OUT);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] beat1_q, beat1_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              begin_q, begin_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_ack_q, rd_ack_d;

  logic [2:0]        rd_out_q, rd_out_d;
  logic              toggle_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q, rd_last_q, err_q;

  logic rd_cand, rd_grant_ok, wr_elig, rd_inc, rd_dec, beat_ok;

  assign wr_elig = wr_req_i;
  // Read counts as waiting for starvation purposes whenever requested and
  // under the cap.
  assign rd_cand = rd_req_i && (rd_out_q < MAX_OUT);
  // During the rd_ack cycle the requester still shows the old request, so a
  // read cannot be re-granted that cycle.
  assign rd_grant_ok = rd_cand && !rd_ack_q;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    beat1_d   = beat1_q;
    write_d   = write_q;
    read_d    = read_q;
    begin_d   = begin_q;
    wr_ack_d  = 1'b0;
    wr_done_d = 1'b0;
    rd_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: if (init_done_i) begin
        if (wr_elig && !(rd_grant_ok && starve_q == STARVE_MAX)) begin
          addr_d   = wr_addr_i;
          wdata_d  = wr_data_i[2*DATA_W-1:DATA_W];
          beat1_d  = wr_data_i[DATA_W-1:0];
          write_d  = 1'b1;
          begin_d  = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = S_WR0;
          if (!rd_cand)                 starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
        end else if (rd_grant_ok) begin
          addr_d   = rd_addr_i;
          read_d   = 1'b1;
          begin_d  = 1'b1;
          starve_d = '0;
          state_d  = S_RD;
        end
      end
      S_WR0: if (avl_ready_i) begin
        wdata_d = beat1_q;
        begin_d = 1'b0;
        state_d = S_WR1;
      end
      S_WR1: if (avl_ready_i) begin
        write_d   = 1'b0;
        wdata_d   = '0;
        wr_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_RD: if (avl_ready_i) begin
        read_d   = 1'b0;
        begin_d  = 1'b0;
        rd_ack_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      beat1_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      begin_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      beat1_q   <= beat1_d;
      write_q   <= write_d;
      read_q    <= read_d;
      begin_q   <= begin_d;
      wr_ack_q  <= wr_ack_d;
      wr_done_q <= wr_done_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  // Return path: a beat with nothing outstanding and no half-burst open is
  // stray and is dropped.
  assign beat_ok = avl_readdatavalid_i && !(rd_out_q == 3'd0 && !toggle_q);
  assign rd_inc  = (state_q == S_RD) && avl_ready_i;
  assign rd_dec  = beat_ok && toggle_q && (rd_out_q != 3'd0);

  always_comb begin
    rd_out_d = rd_out_q;
    if (rd_inc && !rd_dec)      rd_out_d = rd_out_q + 3'd1;
    else if (!rd_inc && rd_dec) rd_out_d = rd_out_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_out_q  <= '0;
      toggle_q  <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_out_q  <= rd_out_d;
      rd_vld_q  <= beat_ok;
      rd_last_q <= beat_ok && toggle_q;
      if (beat_ok) begin
        rd_data_q <= avl_readdata_i;
        toggle_q  <= ~toggle_q;
      end
      if (avl_readdatavalid_i && !beat_ok) err_q <= 1'b1;
    end
  end

  assign wr_ack_o                 = wr_ack_q;
  assign wr_done_o                = wr_done_q;
  assign rd_ack_o                 = rd_ack_q;
  assign rd_data_o                = rd_data_q;
  assign rd_data_valid_o          = rd_vld_q;
  assign rd_beat_last_o           = rd_last_q;
  assign rd_outstanding_o         = rd_out_q;
  assign err_unexp_rd_o           = err_q;
  assign avl_address_o            = addr_q;
  assign avl_write_o              = write_q;
  assign avl_read_o               = read_q;
  assign avl_writedata_o          = wdata_q;
  assign avl_beginbursttransfer_o = begin_q;
  assign avl_burstcount_o         = (write_q || read_q) ? 4'd2 : 4'd0;
  assign avl_byteenable_o         = (write_q || read_q) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_ddr_avl_arbiter.sv
module tb_ddr_avl_arbiter;
  localparam int AW = 25, DW = 64, SMAX = 8, MOUT = 4;

  logic clk;
  logic rst, init_done, wr_req, rd_req, avl_readdatavalid, avl_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [2*DW-1:0] wr_data;
  logic [DW-1:0] avl_readdata;
  logic wr_ack_o, wr_done_o, rd_ack_o, rd_data_valid_o, rd_beat_last_o, err_unexp_rd_o;
  logic [DW-1:0] rd_data_o, avl_writedata_o;
  logic [2:0] rd_outstanding_o;
  logic [AW-1:0] avl_address_o;
  logic avl_write_o, avl_read_o, avl_beginbursttransfer_o;
  logic [3:0] avl_burstcount_o;
  logic [7:0] avl_byteenable_o;

  int nvec = 0, nerr = 0;

  ddr_avl_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_STARVE_MAX(SMAX), .MAX_RD_OUT(MOUT)) dut (
    .clk_i(clk), .rst_i(rst), .init_done_i(init_done),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack_o), .wr_done_o(wr_done_o),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .rd_beat_last_o(rd_beat_last_o),
    .rd_outstanding_o(rd_outstanding_o), .err_unexp_rd_o(err_unexp_rd_o),
    .avl_address_o(avl_address_o), .avl_write_o(avl_write_o), .avl_read_o(avl_read_o),
    .avl_writedata_o(avl_writedata_o), .avl_beginbursttransfer_o(avl_beginbursttransfer_o),
    .avl_burstcount_o(avl_burstcount_o), .avl_byteenable_o(avl_byteenable_o),
    .avl_readdata_i(avl_readdata), .avl_readdatavalid_i(avl_readdatavalid),
    .avl_ready_i(avl_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Avalon slave model: accepted beats/commands are logged, read data is
  // queued as two beats per accepted read and returned in order.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic b; } wbeat_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] b0; logic [DW-1:0] b1; } wreq_t;
  logic [DW-1:0] rq[$];
  wbeat_t        accw[$];
  logic [AW-1:0] accr[$];
  bit            cmd_log[$];   // 0 = write burst, 1 = read burst
  bit            ret_en;
  int            ret_pct;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic b);
    return {8'hA5, 7'd0, a, 23'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input int ready_pct);
    avl_ready = ($urandom_range(99) < ready_pct);
    if (ret_en && rq.size() > 0 && $urandom_range(99) < ret_pct) begin
      avl_readdatavalid = 1'b1;
      avl_readdata = rq.pop_front();
    end else begin
      avl_readdatavalid = 1'b0;
      avl_readdata = '0;
    end
    if (avl_write_o && avl_ready) begin
      accw.push_back({avl_address_o, avl_writedata_o, avl_beginbursttransfer_o});
      if (avl_beginbursttransfer_o) cmd_log.push_back(1'b0);
    end
    if (avl_read_o && avl_ready) begin
      accr.push_back(avl_address_o);
      cmd_log.push_back(1'b1);
      rq.push_back(mem_word(avl_address_o, 1'b0));
      rq.push_back(mem_word(avl_address_o, 1'b1));
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    avl_readdatavalid = 1'b0; avl_readdata = '0; avl_ready = 1'b0;
    rq.delete(); accw.delete(); accr.delete(); cmd_log.delete();
    ret_en = 1'b0; ret_pct = 100;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({wr_ack_o, wr_done_o, rd_ack_o, rd_data_o, rd_data_valid_o, rd_beat_last_o,
         rd_outstanding_o, err_unexp_rd_o, avl_address_o, avl_write_o, avl_read_o,
         avl_writedata_o, avl_beginbursttransfer_o, avl_burstcount_o, avl_byteenable_o} !== '0) begin
      nerr++; $display("FAIL reset_outputs got nonzero outputs");
    end
    // requests while calibration is pending must not reach the bus
    wr_req = 1'b1; rd_req = 1'b1; avl_ready = 1'b1;
    repeat (4) step();
    nvec++;
    if ({avl_write_o, avl_read_o, wr_ack_o} !== 3'b000) begin
      nerr++; $display("FAIL init_gate got=%b exp=000", {avl_write_o, avl_read_o, wr_ack_o});
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_write_only();
    do_reset();
    init_done = 1'b1; avl_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 25'h10; wr_data = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    step();
    nvec++;
    if ({avl_write_o, avl_beginbursttransfer_o, wr_ack_o, avl_address_o, avl_writedata_o, avl_burstcount_o, avl_byteenable_o}
        !== {3'b111, 25'h10, 64'hAAAA_AAAA_AAAA_AAAA, 4'd2, 8'hFF}) begin
      nerr++; $display("FAIL wo_beat0 got w=%b b=%b ack=%b a=%h d=%h", avl_write_o, avl_beginbursttransfer_o, wr_ack_o, avl_address_o, avl_writedata_o);
    end
    wr_req = 1'b0;
    step();
    nvec++;
    if ({avl_write_o, avl_beginbursttransfer_o, wr_ack_o, avl_writedata_o, avl_burstcount_o}
        !== {3'b100, 64'h5555_5555_5555_5555, 4'd2}) begin
      nerr++; $display("FAIL wo_beat1 got w=%b b=%b ack=%b d=%h", avl_write_o, avl_beginbursttransfer_o, wr_ack_o, avl_writedata_o);
    end
    step();
    nvec++;
    if ({avl_write_o, wr_done_o, avl_writedata_o, avl_burstcount_o, avl_byteenable_o, avl_address_o}
        !== {2'b01, 64'd0, 4'd0, 8'h00, 25'h10}) begin
      nerr++; $display("FAIL wo_done got w=%b done=%b d=%h bc=%h be=%h a=%h", avl_write_o, wr_done_o, avl_writedata_o, avl_burstcount_o, avl_byteenable_o, avl_address_o);
    end
    step();
    nvec++;
    if ({wr_done_o, avl_write_o} !== 2'b00) begin
      nerr++; $display("FAIL wo_idle got=%b exp=00", {wr_done_o, avl_write_o});
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    logic [DW-1:0] b0, b1;
    do_reset();
    init_done = 1'b1; avl_ready = 1'b1;
    a = AW'($urandom); b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    wr_req = 1'b1; wr_addr = a; wr_data = {b0, b1};
    step();
    wr_req = 1'b0; avl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++;
      if ({avl_write_o, avl_beginbursttransfer_o, wr_ack_o, avl_address_o, avl_writedata_o} !== {3'b110, a, b0}) begin
        nerr++; $display("FAIL bp_hold0[%0d] got a=%h d=%h b=%b ack=%b exp a=%h d=%h", i, avl_address_o, avl_writedata_o, avl_beginbursttransfer_o, wr_ack_o, a, b0);
      end
    end
    avl_ready = 1'b1;
    step();
    avl_ready = 1'b0;
    nvec++;
    if ({avl_write_o, avl_beginbursttransfer_o, avl_writedata_o} !== {2'b10, b1}) begin
      nerr++; $display("FAIL bp_beat1 got d=%h b=%b exp d=%h", avl_writedata_o, avl_beginbursttransfer_o, b1);
    end
    step(); step();
    nvec++;
    if ({avl_write_o, avl_writedata_o, wr_done_o} !== {1'b1, b1, 1'b0}) begin
      nerr++; $display("FAIL bp_hold1 got d=%h w=%b exp d=%h", avl_writedata_o, avl_write_o, b1);
    end
    avl_ready = 1'b1;
    step();
    nvec++;
    if ({avl_write_o, wr_done_o} !== 2'b01) begin
      nerr++; $display("FAIL bp_done got=%b exp=01", {avl_write_o, wr_done_o});
    end
  endtask

  task automatic test_read_roundtrip();
    do_reset();
    init_done = 1'b1; avl_ready = 1'b1;
    rd_req = 1'b1; rd_addr = 25'h100;
    step();
    nvec++;
    if ({avl_read_o, avl_beginbursttransfer_o, avl_address_o, avl_burstcount_o, rd_ack_o, rd_outstanding_o}
        !== {2'b11, 25'h100, 4'd2, 1'b0, 3'd0}) begin
      nerr++; $display("FAIL rt_cmd got r=%b b=%b a=%h bc=%h", avl_read_o, avl_beginbursttransfer_o, avl_address_o, avl_burstcount_o);
    end
    step();
    nvec++;
    if ({avl_read_o, avl_beginbursttransfer_o, rd_ack_o, rd_outstanding_o} !== {3'b001, 3'd1}) begin
      nerr++; $display("FAIL rt_ack got r=%b ack=%b out=%0d exp ack=1 out=1", avl_read_o, rd_ack_o, rd_outstanding_o);
    end
    rd_req = 1'b0;
    repeat (9) step();
    nvec++;
    if ({rd_ack_o, avl_read_o, rd_data_valid_o} !== 3'b000) begin
      nerr++; $display("FAIL rt_quiet got=%b exp=000", {rd_ack_o, avl_read_o, rd_data_valid_o});
    end
    avl_readdatavalid = 1'b1; avl_readdata = 64'h11;
    step();
    nvec++;
    if ({rd_data_valid_o, rd_beat_last_o, rd_data_o, rd_outstanding_o} !== {2'b10, 64'h11, 3'd1}) begin
      nerr++; $display("FAIL rt_beat0 got v=%b l=%b d=%h out=%0d", rd_data_valid_o, rd_beat_last_o, rd_data_o, rd_outstanding_o);
    end
    avl_readdata = 64'h22;
    step();
    avl_readdatavalid = 1'b0;
    nvec++;
    if ({rd_data_valid_o, rd_beat_last_o, rd_data_o, rd_outstanding_o} !== {2'b11, 64'h22, 3'd0}) begin
      nerr++; $display("FAIL rt_beat1 got v=%b l=%b d=%h out=%0d", rd_data_valid_o, rd_beat_last_o, rd_data_o, rd_outstanding_o);
    end
    step();
    nvec++;
    if ({rd_data_valid_o, err_unexp_rd_o} !== 2'b00) begin
      nerr++; $display("FAIL rt_after got=%b exp=00", {rd_data_valid_o, err_unexp_rd_o});
    end
  endtask

  task automatic test_starvation();
    int s, budget;
    bit exp_r;
    do_reset();
    init_done = 1'b1; ret_en = 1'b1; ret_pct = 100;
    wr_req = 1'b1; wr_addr = 25'h40; wr_data = {64'h1, 64'h2};
    rd_req = 1'b1; rd_addr = 25'h80;
    budget = 0;
    while (cmd_log.size() < 27 && budget < 600) begin
      bus_cycle(100);
      budget++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    nvec++;
    if (cmd_log.size() < 27) begin
      nerr++; $display("FAIL starve_timeout got=%0d cmds exp=27", cmd_log.size());
    end
    // both always waiting: SMAX writes, then the read is forced through
    s = 0;
    for (int i = 0; i < cmd_log.size() && i < 27; i++) begin
      if (s == SMAX) begin exp_r = 1'b1; s = 0; end
      else begin exp_r = 1'b0; s++; end
      nvec++;
      if (cmd_log[i] !== exp_r) begin
        nerr++; $display("FAIL starve_seq[%0d] got=%0d exp=%0d (1=read)", i, cmd_log[i], exp_r);
      end
    end
    repeat (10) bus_cycle(100);
  endtask

  task automatic test_outstanding_cap();
    int acks, wacks, rds, beats;
    do_reset();
    init_done = 1'b1; ret_en = 1'b0;
    rd_req = 1'b1; rd_addr = 25'h200;
    acks = 0;
    repeat (60) begin
      if (rd_ack_o) acks++;
      bus_cycle(100);
    end
    nvec++;
    if (acks !== MOUT) begin nerr++; $display("FAIL cap_acks got=%0d exp=%0d", acks, MOUT); end
    nvec++;
    if (rd_outstanding_o !== 3'(MOUT)) begin nerr++; $display("FAIL cap_count got=%0d exp=%0d", rd_outstanding_o, MOUT); end
    wr_req = 1'b1; wr_addr = 25'h300; wr_data = {64'hF0, 64'hF1};
    wacks = 0; rds = 0;
    repeat (30) begin
      if (wr_ack_o) wacks++;
      if (avl_read_o) rds++;
      bus_cycle(100);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    nvec++;
    if ((wacks >= 8) !== 1'b1) begin nerr++; $display("FAIL cap_writes got=%0d exp>=8", wacks); end
    nvec++;
    if (rds !== 0) begin nerr++; $display("FAIL cap_no_read got=%0d exp=0", rds); end
    ret_en = 1'b1; ret_pct = 100; beats = 0;
    repeat (20) begin
      if (rd_data_valid_o) beats++;
      bus_cycle(100);
    end
    nvec++;
    if ({beats, rd_outstanding_o} !== {32'(2 * MOUT), 3'd0}) begin
      nerr++; $display("FAIL cap_drain got beats=%0d out=%0d exp beats=%0d out=0", beats, rd_outstanding_o, 2 * MOUT);
    end
    rd_req = 1'b1; acks = 0;
    for (int i = 0; i < 10 && acks == 0; i++) begin
      if (rd_ack_o) acks++;
      bus_cycle(100);
    end
    rd_req = 1'b0;
    nvec++;
    if (acks !== 1) begin nerr++; $display("FAIL cap_resume got=%0d exp=1", acks); end
    repeat (10) bus_cycle(100);
  endtask

  task automatic test_reset_error();
    do_reset();
    init_done = 1'b1; avl_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 25'h55; wr_data = {64'h77, 64'h88};
    step();
    wr_req = 1'b0;
    step();
    avl_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if ({wr_ack_o, wr_done_o, rd_ack_o, rd_data_valid_o, rd_outstanding_o, err_unexp_rd_o,
         avl_address_o, avl_write_o, avl_read_o, avl_writedata_o, avl_beginbursttransfer_o,
         avl_burstcount_o, avl_byteenable_o} !== '0) begin
      nerr++; $display("FAIL rst_mid_burst got w=%b a=%h d=%h", avl_write_o, avl_address_o, avl_writedata_o);
    end
    avl_readdatavalid = 1'b1; avl_readdata = 64'hDEAD;
    step();
    avl_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({rd_data_valid_o, err_unexp_rd_o, rd_outstanding_o} !== {2'b01, 3'd0}) begin
        nerr++; $display("FAIL stray_beat[%0d] got v=%b err=%b out=%0d exp v=0 err=1", i, rd_data_valid_o, err_unexp_rd_o, rd_outstanding_o);
      end
      step();
    end
    avl_ready = 1'b1; wr_req = 1'b1; wr_addr = 25'h66; wr_data = {64'h99, 64'hAA};
    step();
    wr_req = 1'b0;
    nvec++;
    if ({avl_write_o, avl_beginbursttransfer_o, avl_address_o, avl_writedata_o, err_unexp_rd_o} !== {2'b11, 25'h66, 64'h99, 1'b1}) begin
      nerr++; $display("FAIL rst_fresh got b=%b a=%h d=%h err=%b", avl_beginbursttransfer_o, avl_address_o, avl_writedata_o, err_unexp_rd_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if (err_unexp_rd_o !== 1'b0) begin nerr++; $display("FAIL err_clear got=%b exp=0", err_unexp_rd_o); end
  endtask

  task automatic test_random();
    wreq_t         expw[$];
    logic [AW-1:0] expr[$];
    logic [DW:0]   exp_rd[$];
    logic [DW:0]   e;
    wbeat_t        wb;
    logic [AW-1:0] ra;
    int out_m, acks, dones;
    bit gen, bus_act;
    do_reset();
    init_done = 1'b1; ret_en = 1'b1; ret_pct = 60;
    out_m = 0; acks = 0; dones = 0;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      gen = (cyc < 3000);
      if (rd_data_valid_o) begin
        nvec++;
        if (exp_rd.size() == 0) begin
          nerr++; $display("FAIL rnd_rd_extra got d=%h", rd_data_o);
        end else begin
          e = exp_rd.pop_front();
          if ({rd_beat_last_o, rd_data_o} !== e) begin
            nerr++; $display("FAIL rnd_rd_data got=%h exp=%h", {rd_beat_last_o, rd_data_o}, e);
          end
        end
        if (rd_beat_last_o) out_m--;
      end
      if (rd_ack_o) begin out_m++; rd_req = 1'b0; end
      nvec++;
      if (rd_outstanding_o !== 3'(out_m) || out_m > MOUT) begin
        nerr++; $display("FAIL rnd_outstanding got=%0d exp=%0d", rd_outstanding_o, out_m);
      end
      bus_act = avl_write_o || avl_read_o;
      nvec++;
      if ({avl_burstcount_o, avl_byteenable_o} !== (bus_act ? {4'd2, 8'hFF} : 12'h000)) begin
        nerr++; $display("FAIL rnd_bc_be got bc=%h be=%h act=%b", avl_burstcount_o, avl_byteenable_o, bus_act);
      end
      if (wr_ack_o) begin acks++; wr_req = 1'b0; end
      if (wr_done_o) dones++;
      while (accw.size() > 0) begin
        wb = accw.pop_front();
        nvec++;
        if (expw.size() == 0) begin
          nerr++; $display("FAIL rnd_wr_extra got a=%h d=%h", wb.a, wb.d);
        end else if (wb.b) begin
          if ({wb.a, wb.d} !== {expw[0].a, expw[0].b0}) begin
            nerr++; $display("FAIL rnd_wr_beat0 got a=%h d=%h exp a=%h d=%h", wb.a, wb.d, expw[0].a, expw[0].b0);
          end
        end else begin
          if ({wb.a, wb.d} !== {expw[0].a, expw[0].b1}) begin
            nerr++; $display("FAIL rnd_wr_beat1 got a=%h d=%h exp a=%h d=%h", wb.a, wb.d, expw[0].a, expw[0].b1);
          end
          void'(expw.pop_front());
        end
      end
      while (accr.size() > 0) begin
        ra = accr.pop_front();
        nvec++;
        if (expr.size() == 0 || ra !== expr[0]) begin
          nerr++; $display("FAIL rnd_rd_addr got=%h exp=%h", ra, (expr.size() > 0) ? expr[0] : '0);
        end
        if (expr.size() > 0) void'(expr.pop_front());
        exp_rd.push_back({1'b0, mem_word(ra, 1'b0)});
        exp_rd.push_back({1'b1, mem_word(ra, 1'b1)});
      end
      if (gen && !wr_req && !wr_ack_o && $urandom_range(3) == 0) begin
        wr_addr = AW'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        wr_req = 1'b1;
        expw.push_back({wr_addr, wr_data});
      end
      if (gen && !rd_req && !rd_ack_o && $urandom_range(3) == 0) begin
        rd_addr = AW'($urandom);
        rd_req = 1'b1;
        expr.push_back(rd_addr);
      end
      bus_cycle(70);
    end
    nvec++;
    if ({expw.size(), expr.size(), exp_rd.size(), out_m} !== 128'd0) begin
      nerr++; $display("FAIL rnd_drain got w=%0d r=%0d beats=%0d out=%0d exp all 0", expw.size(), expr.size(), exp_rd.size(), out_m);
    end
    nvec++;
    if ({acks == dones, err_unexp_rd_o} !== 2'b10) begin
      nerr++; $display("FAIL rnd_ack_done got acks=%0d dones=%0d err=%b", acks, dones, err_unexp_rd_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_backpressure();
    test_read_roundtrip();
    test_starvation();
    test_outstanding_cap();
    test_reset_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
